// File: rtl/nn_pkg.sv
// Shared constants, state encoding and saturation helper for the 256-20-10
// inference sequencer.
package nn_pkg;

    localparam int N_IN  = 256;
    localparam int N_HID = 20;
    localparam int N_OUT = 10;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;

    // The data port carries one spare address bit above the pixel count.
    localparam int DATA_AW = $clog2(N_IN) + 1;
    localparam int W12_AW  = $clog2(N_IN * N_HID);
    localparam int B12_AW  = $clog2(N_HID);
    localparam int W23_AW  = $clog2(N_HID * N_OUT);
    localparam int B23_AW  = $clog2(N_OUT);

    // Loop counter widths for pixel (i), hidden (j) and output (k) indices.
    localparam int I_W = $clog2(N_IN);
    localparam int J_W = $clog2(N_HID);
    localparam int K_W = $clog2(N_OUT);

    localparam logic signed [ACC_W-1:0] HID_MAX = ACC_W'((1 << (DW - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_MAC,
        S_L1_BIAS,
        S_L1_WB,
        S_L2_MAC,
        S_L2_BIAS,
        S_L2_CMP,
        S_FIN
    } state_t;

    // ReLU followed by saturation to the largest positive DW value.
    function automatic logic [DW-1:0] sat_relu(input logic signed [ACC_W-1:0] x);
        if (x < 0) begin
            return '0;
        end
        if (x > HID_MAX) begin
            return HID_MAX[DW-1:0];
        end
        return x[DW-1:0];
    endfunction

endpackage

// File: rtl/nn_infer_sequencer_if.sv
// Host handshake plus weight/data memory read bus of the inference sequencer.
interface nn_infer_sequencer_if;
    import nn_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [N_OUT-1:0]     onehot_enc;
    logic [DATA_AW-1:0]   data_rdaddr;
    logic [1:0]           data_rddata;
    logic [W12_AW-1:0]    w12_rdaddr;
    logic [DW-1:0]        w12_rddata;
    logic [B12_AW-1:0]    b12_rdaddr;
    logic [DW-1:0]        b12_rddata;
    logic [W23_AW-1:0]    w23_rdaddr;
    logic [DW-1:0]        w23_rddata;
    logic [B23_AW-1:0]    b23_rdaddr;
    logic [DW-1:0]        b23_rddata;
    logic                 rd_en;

    // Sequencer side: issues addresses, consumes read data and start.
    modport master (
        input  start, data_rddata, w12_rddata, b12_rddata, w23_rddata, b23_rddata,
        output busy, done, onehot_enc, data_rdaddr, w12_rdaddr, b12_rdaddr,
               w23_rdaddr, b23_rdaddr, rd_en
    );

    // Host/memory side.
    modport slave (
        output start, data_rddata, w12_rddata, b12_rddata, w23_rddata, b23_rddata,
        input  busy, done, onehot_enc, data_rdaddr, w12_rdaddr, b12_rdaddr,
               w23_rdaddr, b23_rdaddr, rd_en
    );

endinterface

// File: rtl/nn_mac_unit.sv
// Shared signed multiply-accumulate unit. Layer 1 multiplies a 2-bit pixel by
// a DW weight, layer 2 multiplies a DW hidden activation by a DW weight.
// sum_o presents acc plus the bias, optionally aligned from Q8.8 to Q16.16.
module nn_mac_unit
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    sel_l2_i,
    input  logic [1:0]              pix_i,
    input  logic [DW-1:0]           hid_i,
    input  logic [DW-1:0]           w_l1_i,
    input  logic [DW-1:0]           w_l2_i,
    input  logic [DW-1:0]           bias_i,
    input  logic                    bias_shift_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [DW-1:0]    op_a;
    logic signed [DW-1:0]    op_b;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Operand select, product and bias alignment.
    always_comb begin
        op_a     = sel_l2_i ? hid_i : {{(DW-2){pix_i[1]}}, pix_i};
        op_b     = sel_l2_i ? w_l2_i : w_l1_i;
        prod     = op_a * op_b;
        bias_ext = {{(ACC_W-DW){bias_i[DW-1]}}, bias_i};
        if (bias_shift_i) begin
            bias_ext = bias_ext <<< FRAC;
        end
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
    end

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
    assign sum_o = acc_q + bias_ext;

endmodule

// File: rtl/nn_infer_sequencer.sv
// Sequences one 256-20-10 fully-connected inference through a single shared
// MAC: address generation, hidden buffer, bias/ReLU/saturation and argmax.
module nn_infer_sequencer
    import nn_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    nn_infer_sequencer_if.master bus
);

    state_t state_q, state_d;
    logic [I_W-1:0]      i_q, i_d;
    logic [J_W-1:0]      j_q, j_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_OUT-1:0]    onehot_q, onehot_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic [K_W-1:0]      idx_q, idx_d;
    logic [DATA_AW-1:0]  data_addr_q, data_addr_d;
    logic [W12_AW-1:0]   w12_addr_q, w12_addr_d;
    logic [B12_AW-1:0]   b12_addr_q, b12_addr_d;
    logic [W23_AW-1:0]   w23_addr_q, w23_addr_d;
    logic [B23_AW-1:0]   b23_addr_q, b23_addr_d;
    logic                rd_en_q, rd_en_d;
    logic                mac_vld_q, mac_l2_q;
    logic                mac_clr, hid_we, in_cmp;
    logic signed [ACC_W-1:0] mac_acc, mac_sum;
    logic [DW-1:0]       hidden_q [N_HID];
    logic [DW-1:0]       hid_op_q;

    assign in_cmp = (state_q == S_L2_CMP);

    nn_mac_unit u_mac (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (mac_clr),
        .en_i         (mac_vld_q),
        .sel_l2_i     (mac_l2_q),
        .pix_i        (bus.data_rddata),
        .hid_i        (hid_op_q),
        .w_l1_i       (bus.w12_rddata),
        .w_l2_i       (bus.w23_rddata),
        .bias_i       (in_cmp ? bus.b23_rddata : bus.b12_rddata),
        .bias_shift_i (in_cmp),
        .acc_o        (mac_acc),
        .sum_o        (mac_sum)
    );

    // Next-state, loop counters, hidden write-back and argmax.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        onehot_d = onehot_q;
        best_d   = best_q;
        idx_d    = idx_q;
        mac_clr  = 1'b0;
        hid_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                mac_clr = 1'b1;
                if (bus.start) begin
                    state_d = S_L1_MAC;
                    i_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            S_L1_MAC: begin
                if (i_q == I_W'(N_IN - 1)) state_d = S_L1_BIAS;
                else                       i_d     = i_q + 1'b1;
            end
            S_L1_BIAS: state_d = S_L1_WB;
            S_L1_WB: begin
                hid_we  = 1'b1;
                mac_clr = 1'b1;
                i_d     = '0;
                if (j_q == J_W'(N_HID - 1)) begin
                    state_d = S_L2_MAC;
                    j_d     = '0;
                    k_d     = '0;
                end else begin
                    state_d = S_L1_MAC;
                    j_d     = j_q + 1'b1;
                end
            end
            S_L2_MAC: begin
                if (j_q == J_W'(N_HID - 1)) state_d = S_L2_BIAS;
                else                        j_d     = j_q + 1'b1;
            end
            S_L2_BIAS: state_d = S_L2_CMP;
            S_L2_CMP: begin
                mac_clr = 1'b1;
                // Strict greater-than keeps the lowest index on ties.
                if (k_q == '0 || mac_sum > best_q) begin
                    best_d = mac_sum;
                    idx_d  = k_q;
                end
                if (k_q == K_W'(N_OUT - 1)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_L2_MAC;
                    k_d     = k_q + 1'b1;
                    j_d     = '0;
                end
            end
            S_FIN: begin
                state_d  = S_IDLE;
                onehot_d = N_OUT'(1) << idx_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered read addresses for the cycle about to be entered; held otherwise.
    always_comb begin
        data_addr_d = data_addr_q;
        w12_addr_d  = w12_addr_q;
        b12_addr_d  = b12_addr_q;
        w23_addr_d  = w23_addr_q;
        b23_addr_d  = b23_addr_q;
        rd_en_d     = 1'b0;
        case (state_d)
            S_L1_MAC: begin
                data_addr_d = DATA_AW'(i_d);
                w12_addr_d  = W12_AW'(j_d) * W12_AW'(N_IN) + W12_AW'(i_d);
                rd_en_d     = 1'b1;
            end
            S_L1_BIAS: begin
                b12_addr_d = B12_AW'(j_d);
                rd_en_d    = 1'b1;
            end
            S_L2_MAC: begin
                w23_addr_d = W23_AW'(k_d) * W23_AW'(N_HID) + W23_AW'(j_d);
                rd_en_d    = 1'b1;
            end
            S_L2_BIAS: begin
                b23_addr_d = B23_AW'(k_d);
                rd_en_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Control and address registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            onehot_q    <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            data_addr_q <= '0;
            w12_addr_q  <= '0;
            b12_addr_q  <= '0;
            w23_addr_q  <= '0;
            b23_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            mac_vld_q   <= 1'b0;
            mac_l2_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            onehot_q    <= onehot_d;
            best_q      <= best_d;
            idx_q       <= idx_d;
            data_addr_q <= data_addr_d;
            w12_addr_q  <= w12_addr_d;
            b12_addr_q  <= b12_addr_d;
            w23_addr_q  <= w23_addr_d;
            b23_addr_q  <= b23_addr_d;
            rd_en_q     <= rd_en_d;
            // Read data returns one cycle after a MAC address, so the product is valid then.
            mac_vld_q   <= (state_q == S_L1_MAC) || (state_q == S_L2_MAC);
            mac_l2_q    <= (state_q == S_L2_MAC);
        end
    end

    // Hidden activation buffer and the layer-2 operand aligned with w23 read data.
    always_ff @(posedge clk) begin
        // NOTE: the hidden buffer is storage, not control state, so it is deliberately left out of reset.
        if (reset && hid_we) begin
            hidden_q[j_q] <= sat_relu(mac_sum);
        end
        hid_op_q <= hidden_q[j_q];
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.onehot_enc  = onehot_q;
    assign bus.data_rdaddr = data_addr_q;
    assign bus.w12_rdaddr  = w12_addr_q;
    assign bus.b12_rdaddr  = b12_addr_q;
    assign bus.w23_rdaddr  = w23_addr_q;
    assign bus.b23_rdaddr  = b23_addr_q;
    assign bus.rd_en       = rd_en_q;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Directed self-checking bench for nn_infer_sequencer with 1-cycle-latency
// memory models and a behavioural golden model for random images.
module tb_nn_infer_sequencer;
    import nn_pkg::*;

    localparam int LAT = 5381;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    nn_infer_sequencer_if bus ();

    nn_infer_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    data_mem [N_IN];
    logic [DW-1:0] w12_mem  [N_IN*N_HID];
    logic [DW-1:0] b12_mem  [N_HID];
    logic [DW-1:0] w23_mem  [N_HID*N_OUT];
    logic [DW-1:0] b23_mem  [N_OUT];

    // Synchronous-read memory models: data valid one cycle after the address.
    always @(posedge clk) begin
        bus.data_rddata <= data_mem[bus.data_rdaddr[I_W-1:0]];
        bus.w12_rddata  <= w12_mem[bus.w12_rdaddr];
        bus.b12_rddata  <= b12_mem[bus.b12_rdaddr];
        bus.w23_rddata  <= w23_mem[bus.w23_rdaddr];
        bus.b23_rddata  <= b23_mem[bus.b23_rdaddr];
    end

    // Records the order of distinct w12 addresses while enabled.
    logic mon_en;
    logic mon_first;
    int   mon_cnt;
    int   mon_err;
    logic [W12_AW-1:0] mon_last;
    always @(negedge clk) begin
        if (mon_en && bus.rd_en && (mon_first || bus.w12_rdaddr != mon_last)) begin
            if (int'(bus.w12_rdaddr) != mon_cnt) mon_err++;
            mon_cnt++;
            mon_last  = bus.w12_rdaddr;
            mon_first = 1'b0;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mems();
        foreach (data_mem[a]) data_mem[a] = '0;
        foreach (w12_mem[a])  w12_mem[a]  = '0;
        foreach (b12_mem[a])  b12_mem[a]  = '0;
        foreach (w23_mem[a])  w23_mem[a]  = '0;
        foreach (b23_mem[a])  b23_mem[a]  = '0;
    endtask

    // Behavioural reference: straightforward nested loops in 64-bit arithmetic.
    function automatic logic [N_OUT-1:0] golden();
        longint h [N_HID];
        longint acc;
        longint best;
        int     idx;
        for (int j = 0; j < N_HID; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                acc += longint'($signed(data_mem[i])) * longint'($signed(w12_mem[j*N_IN+i]));
            acc += longint'($signed(b12_mem[j]));
            h[j] = (acc < 0) ? 0 : ((acc > 32767) ? 32767 : acc);
        end
        best = 0;
        idx  = 0;
        for (int k = 0; k < N_OUT; k++) begin
            acc = longint'($signed(b23_mem[k])) * 256;
            for (int j = 0; j < N_HID; j++)
                acc += h[j] * longint'($signed(w23_mem[k*N_HID+j]));
            if (k == 0 || acc > best) begin
                best = acc;
                idx  = k;
            end
        end
        return N_OUT'(1) << idx;
    endfunction

    task automatic random_image(input bit all_mems);
        int t;
        foreach (data_mem[a]) data_mem[a] = 2'($urandom);
        if (all_mems) begin
            foreach (w12_mem[a]) begin t = int'($urandom_range(0, 1023)) - 512;  w12_mem[a] = DW'(t); end
            foreach (b12_mem[a]) begin t = int'($urandom_range(0, 511)) - 256;   b12_mem[a] = DW'(t); end
            foreach (w23_mem[a]) begin t = int'($urandom_range(0, 4095)) - 2048; w23_mem[a] = DW'(t); end
            foreach (b23_mem[a]) begin t = int'($urandom_range(0, 127)) - 64;    b23_mem[a] = DW'(t); end
        end
    endtask

    // Called at a negedge with the DUT idle. Starts one inference, optionally
    // pulses start again at cycle pulse_at, and returns linger cycles after done.
    task automatic run_image(input int pulse_at, input int linger, output int lat,
                             output int n_done, output bit busy_ok, output bit busy_after);
        lat        = -1;
        n_done     = 0;
        busy_ok    = 1'b1;
        busy_after = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (!bus.busy) busy_ok = 1'b0;
        for (int n = 1; n <= LAT + 100; n++) begin
            @(negedge clk);
            bus.start = (n == pulse_at);
            if (bus.done) begin
                n_done++;
                if (lat < 0) begin
                    lat        = n;
                    busy_after = bus.busy;
                end
            end else if (lat < 0 && !bus.busy) begin
                busy_ok = 1'b0;
            end
            if (lat >= 0 && n >= lat + linger) break;
        end
        bus.start = 1'b0;
    endtask

    int lat, n_done;
    bit busy_ok, busy_after;
    logic [N_OUT-1:0] exp1, exp2;

    initial begin
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b0;
        mon_first = 1'b0;
        mon_cnt   = 0;
        mon_err   = 0;
        mon_last  = '0;
        bus.start = 1'b0;
        reset     = 1'b0;
        clear_mems();
        repeat (3) @(negedge clk);

        check("rst_busy",   longint'(bus.busy), 0);
        check("rst_done",   longint'(bus.done), 0);
        check("rst_onehot", longint'(bus.onehot_enc), 0);
        check("rst_rd_en",  longint'(bus.rd_en), 0);
        check("rst_w12",    longint'(bus.w12_rdaddr), 0);
        check("rst_data",   longint'(bus.data_rdaddr), 0);
        reset = 1'b1;
        @(negedge clk);

        // Only b23[3] nonzero: class 3 wins, latency and busy window checked.
        b23_mem[3] = 16'd5;
        run_image(0, 3, lat, n_done, busy_ok, busy_after);
        check("a_latency", lat, LAT);
        check("a_done_cnt", n_done, 1);
        check("a_busy_hi", longint'(busy_ok), 1);
        check("a_busy_lo", longint'(busy_after), 0);
        check("a_onehot", longint'(bus.onehot_enc), 10'b0000001000);
        check("a_rd_en_idle", longint'(bus.rd_en), 0);

        // Full tie: lowest index wins.
        clear_mems();
        run_image(0, 1, lat, n_done, busy_ok, busy_after);
        check("tie_onehot", longint'(bus.onehot_enc), 10'b0000000001);
        check("tie_latency", lat, LAT);

        // Saturation: every hidden clamps to 32767, class 7 wins.
        clear_mems();
        foreach (data_mem[a]) data_mem[a] = 2'b01;
        foreach (w12_mem[a])  w12_mem[a]  = 16'h7FFF;
        for (int j = 0; j < N_HID; j++) w23_mem[7*N_HID+j] = 16'h0100;
        run_image(0, 1, lat, n_done, busy_ok, busy_after);
        check("sat_onehot", longint'(bus.onehot_enc), 10'b0010000000);
        check("sat_hid0",  longint'(dut.hidden_q[0]), 32767);
        check("sat_hid19", longint'(dut.hidden_q[N_HID-1]), 32767);

        // Same weights, all pixels -1: ReLU zeroes every hidden, tie -> class 0.
        foreach (data_mem[a]) data_mem[a] = 2'b11;
        run_image(0, 1, lat, n_done, busy_ok, busy_after);
        check("relu_onehot", longint'(bus.onehot_enc), 10'b0000000001);
        check("relu_hid5",  longint'(dut.hidden_q[5]), 0);

        // Start pulsed mid-inference is ignored.
        clear_mems();
        b23_mem[3] = 16'd5;
        run_image(1000, 8, lat, n_done, busy_ok, busy_after);
        check("pulse_latency", lat, LAT);
        check("pulse_done_cnt", n_done, 1);
        check("pulse_onehot", longint'(bus.onehot_enc), 10'b0000001000);

        // Reset at cycle 2000 of an inference aborts at the next edge.
        foreach (data_mem[a]) data_mem[a] = 2'b01;
        foreach (w12_mem[a])  w12_mem[a]  = 16'h7FFF;
        b23_mem[3] = 16'd0;
        for (int j = 0; j < N_HID; j++) w23_mem[7*N_HID+j] = 16'h0100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (1999) @(negedge clk);
        check("mid_busy", longint'(bus.busy), 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy",   longint'(bus.busy), 0);
        check("abort_onehot", longint'(bus.onehot_enc), 0);
        check("abort_done",   longint'(bus.done), 0);
        check("abort_rd_en",  longint'(bus.rd_en), 0);
        check("abort_w12",    longint'(bus.w12_rdaddr), 0);
        reset = 1'b1;
        @(negedge clk);
        run_image(0, 1, lat, n_done, busy_ok, busy_after);
        check("restart_latency", lat, LAT);
        check("restart_onehot", longint'(bus.onehot_enc), 10'b0010000000);

        // Two back-to-back random images with different pixel data.
        random_image(1'b1);
        exp1      = golden();
        mon_cnt   = 0;
        mon_err   = 0;
        mon_first = 1'b1;
        mon_en    = 1'b1;
        run_image(0, 0, lat, n_done, busy_ok, busy_after);
        mon_en    = 1'b0;
        check("b2b1_latency", lat, LAT);
        check("b2b1_onehot", longint'(bus.onehot_enc), longint'(exp1));
        check("w12_seq_cnt", mon_cnt, N_IN*N_HID);
        check("w12_seq_err", mon_err, 0);
        random_image(1'b0);
        exp2 = golden();
        run_image(0, 1, lat, n_done, busy_ok, busy_after);
        check("b2b2_latency", lat, LAT);
        check("b2b2_onehot", longint'(bus.onehot_enc), longint'(exp2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn_infer_sequencer.md
Name: nn_infer_sequencer

Overview:
- Sequences one complete 256-20-10 fully-connected inference for digit recognition, using a single shared multiply-accumulate unit.
- Generates read addresses for the externally loaded data, w12, b12, w23 and b23 memories, and keeps the 20 hidden activations in an internal buffer.
- Applies bias, ReLU and saturation, runs an argmax over the 10 outputs and presents onehot_enc.
- Sits between the weight/data memories and the host start/done handshake in the inference top.

Parameters:
- N_IN, 256, input pixels per image (2-bit signed each)
- N_HID, 20, hidden neurons
- N_OUT, 10, output classes
- DW, 16, weight/bias/hidden width, signed Q8.8
- FRAC, 8, fractional bits of DW values
- ACC_W, 40, accumulator width, signed

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin inference; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when onehot_enc is updated
- onehot_enc  out  N_OUT  one-hot winning class
- data_rdaddr  out  9  data memory read address
- data_rddata  in  2  signed pixel, valid 1 cycle after address
- w12_rdaddr  out  13  address = j*N_IN+i
- w12_rddata  in  DW  signed weight, 1-cycle latency
- b12_rdaddr  out  5  address = j
- b12_rddata  in  DW  signed bias, 1-cycle latency
- w23_rdaddr  out  8  address = k*N_HID+j
- w23_rddata  in  DW  signed weight, 1-cycle latency
- b23_rdaddr  out  4  address = k
- b23_rddata  in  DW  signed bias, 1-cycle latency
- rd_en  out  1  high in every cycle an address is issued

Behaviour:
- Reset (reset=0 at a clock edge):
  - State becomes IDLE; busy=0, done=0, onehot_enc=0, all addresses 0, rd_en=0, accumulator 0.
  - The hidden buffer is not cleared.
- States: IDLE, L1_MAC, L1_BIAS, L1_WB, L2_MAC, L2_BIAS, L2_CMP, FIN.
- IDLE:
  - start=1 leads to L1_MAC with j=0, i=0, accumulator=0 and busy=1.
  - start while busy is ignored.
- L1_MAC (N_IN cycles):
  - Issues data_rdaddr=i and w12_rdaddr=j*N_IN+i for i=0..N_IN-1.
  - Each returned pair is accumulated one cycle later: acc += sext(data)*sext(w12).
- L1_BIAS (1 cycle): accumulates the final product and issues b12_rdaddr=j.
- L1_WB (1 cycle):
  - hidden[j] = clamp(acc + sext(b12), 0, 32767), i.e. ReLU then saturate to DW.
  - Clears acc.
  - Goes to L1_MAC with j+1, or to L2_MAC with k=0 after j=N_HID-1.
- L2_MAC (N_HID cycles): issues w23_rdaddr=k*N_HID+j; one cycle later acc += hidden[j]*sext(w23) (Q16.16).
- L2_BIAS (1 cycle): accumulates the last product and issues b23_rdaddr=k.
- L2_CMP (1 cycle):
  - score = acc + (sext(b23) <<< FRAC).
  - If k=0 or score > best (strict greater-than), then best=score and idx=k. Ties keep the lower index.
  - Clears acc.
  - Goes to L2_MAC with k+1, or to FIN after k=N_OUT-1.
- FIN (1 cycle): onehot_enc = 1<<idx, done=1, busy=0, then IDLE.
- onehot_enc holds its value until the next FIN.
- Latency: accepted start edge to done high = N_HID*(N_IN+2) + N_OUT*(N_HID+2) + 1 = 5381 cycles.
- Back-to-back operation: start may be reasserted in the cycle after done.
- No overflow is possible at default widths (|acc| < 2^39). Arithmetic is two's complement throughout.
- Reset mid-inference aborts immediately. Memory contents are untouched; the next start restarts from j=0.
- rd_en=0 and addresses hold their last value in IDLE and FIN.

Decomposition:
- Shared package nn_pkg holds:
  - state enum
  - N_IN/N_HID/N_OUT/DW/FRAC/ACC_W constants
  - address-width localparams (clog2 of each memory depth)
  - sat_relu function
- Single natural sub-module: nn_mac_unit.
  - Signed multiplier plus ACC_W accumulator.
  - Inputs: clr, en, operand-select (layer 1 = 2-bit×DW, layer 2 = DW×DW), bias-add with optional <<<FRAC.
- The sequencer keeps the FSM, counters i/j/k, hidden buffer and argmax.

Test Plan:
- All weights 0, b12=0, b23[3]=5, others 0; start → done exactly 5381 cycles after start; onehot_enc=10'b0000001000; busy high throughout.
- All weights/biases 0 (full tie) → onehot_enc=10'b0000000001.
- Saturation/ReLU case:
  - Stimulus: all pixels +1, w12=0x7FFF, b12=0; w23[k*20+j]=0x0100 for k=7 only; b23=0.
  - Required response: every hidden=32767 and onehot_enc bit 7 set.
  - Repeat with all pixels -1: hidden=0 (ReLU), onehot_enc=bit 0.
- start pulsed again at cycle 1000 of an inference → ignored; done still at cycle 5381; only one done pulse.
- reset=0 at cycle 2000 → next edge busy=0, onehot_enc=0, state IDLE. A new start then gives the correct result 5381 cycles later.
- Two back-to-back images (start the cycle after done) with different data memories → each onehot_enc matches the golden model; w12_rdaddr sequence checked 0..5119 in order.
